// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic row controller.
// State encoding, default data widths and the row latency calculation.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int SA_DATA_BW   = 8;
    localparam int SA_WEIGHT_BW = 8;
    localparam int SA_PSUM_BW   = 20;

    // Cycles from din output register to final psum of the row, plus capture.
    function automatic int calc_lat(input int matrix_size, input int pe_lat);
        return matrix_size * pe_lat + 1;
    endfunction

endpackage

// File: rtl/sa_row_ctrl_if.sv
// Host-side bundle of the systolic row controller: weight load handshake,
// input vector stream handshake and the result stream.
interface sa_row_ctrl_if #(
    parameter int MATRIX_SIZE = 8,
    parameter int WEIGHT_BW   = sa_pkg::SA_WEIGHT_BW,
    parameter int DATA_BW     = sa_pkg::SA_DATA_BW,
    parameter int PSUM_BW     = sa_pkg::SA_PSUM_BW
) ();

    logic                             w_valid;
    logic                             w_ready;
    logic [MATRIX_SIZE*WEIGHT_BW-1:0] w_data;
    logic                             in_valid;
    logic                             in_ready;
    logic [MATRIX_SIZE*DATA_BW-1:0]   in_data;
    logic                             in_last;
    logic                             out_valid;
    logic [PSUM_BW-1:0]               out_data;

    // Producer of weights/vectors and consumer of results.
    modport master (
        output w_valid, w_data, in_valid, in_data, in_last,
        input  w_ready, in_ready, out_valid, out_data
    );

    // The controller side.
    modport slave (
        input  w_valid, w_data, in_valid, in_data, in_last,
        output w_ready, in_ready, out_valid, out_data
    );

endinterface

// File: rtl/sa_skew_line.sv
// One lane of the diagonal input skew: a zero-reset delay line of DEPTH
// registers. DEPTH of 0 degenerates to a plain wire.
module sa_skew_line #(
    parameter int W     = 8,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] d_out
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Clock and reset are not needed on a zero-depth lane.
            logic unused_ok;
            assign unused_ok = ^{clk, rstn};
            assign d_out     = d_in;
        end else begin : g_shift
            logic [W-1:0] stage_reg [DEPTH];
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    // First stage takes the lane input.
                    always_ff @(posedge clk or negedge rstn) begin
                        if (!rstn) stage_reg[0] <= '0;
                        else       stage_reg[0] <= d_in;
                    end
                end else begin : g_body
                    // Remaining stages shift along the chain.
                    always_ff @(posedge clk or negedge rstn) begin
                        if (!rstn) stage_reg[gi] <= '0;
                        else       stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end
            assign d_out = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sa_row_ctrl.sv
// Sequencer for one horizontal systolic PE row: loads weights, skews the
// input vectors diagonally, tracks in-flight vectors and captures the row's
// final partial sum as a validated result stream.
// Optional build macro SA_ROW_CTRL_PERF_EN adds busy-cycle and accepted-vector
// counters (32-bit, saturating).
module sa_row_ctrl
    import sa_pkg::*;
#(
    parameter int WEIGHT_BW   = SA_WEIGHT_BW,
    parameter int DATA_BW     = SA_DATA_BW,
    parameter int PSUM_BW     = SA_PSUM_BW,
    parameter int MATRIX_SIZE = 8,
    parameter int PE_LAT      = 1
) (
    input  logic                             clk,
    input  logic                             rstn,
    sa_row_ctrl_if.slave                     host,
    output logic                             we_rl,
    output logic [MATRIX_SIZE*WEIGHT_BW-1:0] weights,
    output logic [MATRIX_SIZE*DATA_BW-1:0]   din,
    input  logic signed [PSUM_BW-1:0]        row_result,
    output logic                             busy,
    output logic                             done
`ifdef SA_ROW_CTRL_PERF_EN
    ,
    output logic [31:0]                      perf_busy_cycles,
    output logic [31:0]                      perf_vec_count
`endif
);

    localparam int LAT   = calc_lat(MATRIX_SIZE, PE_LAT);
    localparam int CNT_W = $clog2(LAT + 1);

    state_t                           state_reg, state_next;
    logic [CNT_W-1:0]                 cnt_reg, cnt_next;
    logic                             done_next;
    logic                             w_ready_reg, in_ready_reg, we_rl_reg;
    logic                             busy_reg, done_reg;
    logic [MATRIX_SIZE*WEIGHT_BW-1:0] weights_reg;
    logic [MATRIX_SIZE*DATA_BW-1:0]   din_reg;
    logic [LAT-1:0]                   vtrack_reg;
    logic                             out_valid_reg;
    logic [PSUM_BW-1:0]               out_data_reg;
    logic                             w_acc, in_acc;
    logic [DATA_BW-1:0]               lane_in  [MATRIX_SIZE];
    logic [DATA_BW-1:0]               lane_out [MATRIX_SIZE];

    // Handshakes qualify on the registered ready flags seen by the host.
    assign w_acc  = host.w_valid  & w_ready_reg;
    assign in_acc = host.in_valid & in_ready_reg;

    // Next-state logic and drain countdown.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        unique case (state_reg)
            IDLE:    if (w_acc) state_next = LOAD;
            LOAD:    state_next = STREAM;
            STREAM: begin
                if (in_acc && host.in_last) begin
                    state_next = DRAIN;
                    cnt_next   = CNT_W'(LAT - 1);
                end
            end
            DRAIN: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus registered control outputs decoded from next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            w_ready_reg  <= 1'b0;
            in_ready_reg <= 1'b0;
            we_rl_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            w_ready_reg  <= (state_next == IDLE);
            in_ready_reg <= (state_next == STREAM);
            we_rl_reg    <= (state_next == LOAD);
            busy_reg     <= (state_next != IDLE);
            done_reg     <= done_next;
        end
    end

    // Weight register, only written from IDLE so it is stable during a stream.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      weights_reg <= '0;
        else if (w_acc) weights_reg <= host.w_data;
    end

    // Lane i is delayed by i*PE_LAT; idle cycles inject zeros.
    generate
        for (genvar gi = 0; gi < MATRIX_SIZE; gi++) begin : g_lane
            assign lane_in[gi] = in_acc ? host.in_data[gi*DATA_BW +: DATA_BW] : '0;
            sa_skew_line #(
                .W     (DATA_BW),
                .DEPTH (gi * PE_LAT)
            ) u_skew (
                .clk   (clk),
                .rstn  (rstn),
                .d_in  (lane_in[gi]),
                .d_out (lane_out[gi])
            );
        end
    endgenerate

    // Output register shared by all lanes, so lane 0 still sees one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            din_reg <= '0;
        end else begin
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                din_reg[i*DATA_BW +: DATA_BW] <= lane_out[i];
            end
        end
    end

    // Valid tracker: its tap lines up with the vector's psum leaving the row.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) vtrack_reg <= '0;
        else       vtrack_reg <= {vtrack_reg[LAT-2:0], in_acc};
    end

    // Result capture; data holds between valid pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= vtrack_reg[LAT-1];
            if (vtrack_reg[LAT-1]) out_data_reg <= row_result;
        end
    end

`ifdef SA_ROW_CTRL_PERF_EN
    logic [31:0] perf_busy_reg, perf_vec_reg;

    // Saturating activity counters, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_busy_reg <= '0;
            perf_vec_reg  <= '0;
        end else begin
            if (busy_reg && (perf_busy_reg != '1)) perf_busy_reg <= perf_busy_reg + 1'b1;
            if (in_acc   && (perf_vec_reg  != '1)) perf_vec_reg  <= perf_vec_reg + 1'b1;
        end
    end

    assign perf_busy_cycles = perf_busy_reg;
    assign perf_vec_count   = perf_vec_reg;
`endif

    assign host.w_ready   = w_ready_reg;
    assign host.in_ready  = in_ready_reg;
    assign host.out_valid = out_valid_reg;
    assign host.out_data  = out_data_reg;
    assign we_rl          = we_rl_reg;
    assign weights        = weights_reg;
    assign din            = din_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;

endmodule

// File: tb/tb_sa_row_ctrl.sv
// Self-checking bench for sa_row_ctrl. A behavioural PE row closes the loop
// on row_result; the reference tracks expected events by cycle number from
// the handshake rules (results at accept+LAT+1, done at last+LAT+1).
module tb_sa_row_ctrl;

    localparam int MS  = 8;
    localparam int WBW = 8;
    localparam int DBW = 8;
    localparam int PBW = 20;
    localparam int PEL = 1;
    localparam int LAT = MS * PEL + 1;
    localparam int BIG = 32'h3fff_ffff;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    sa_row_ctrl_if #(.MATRIX_SIZE(MS), .WEIGHT_BW(WBW), .DATA_BW(DBW), .PSUM_BW(PBW)) bus ();

    logic                   we_rl, busy, done;
    logic [MS*WBW-1:0]      weights;
    logic [MS*DBW-1:0]      din;
    logic signed [PBW-1:0]  row_result;
`ifdef SA_ROW_CTRL_PERF_EN
    logic [31:0]            perf_busy_cycles, perf_vec_count;
`endif

    sa_row_ctrl #(
        .WEIGHT_BW(WBW), .DATA_BW(DBW), .PSUM_BW(PBW), .MATRIX_SIZE(MS), .PE_LAT(PEL)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .host       (bus.slave),
        .we_rl      (we_rl),
        .weights    (weights),
        .din        (din),
        .row_result (row_result),
        .busy       (busy),
        .done       (done)
`ifdef SA_ROW_CTRL_PERF_EN
        ,
        .perf_busy_cycles (perf_busy_cycles),
        .perf_vec_count   (perf_vec_count)
`endif
    );

    // Behavioural PE row: latch weights on we_rl, psum += w*din per PE.
    logic [WBW-1:0]        pe_w    [MS];
    logic signed [PBW-1:0] pe_psum [MS];
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int j = 0; j < MS; j++) begin
                pe_w[j]    <= '0;
                pe_psum[j] <= '0;
            end
        end else begin
            if (we_rl) for (int j = 0; j < MS; j++) pe_w[j] <= weights[j*WBW +: WBW];
            for (int j = 0; j < MS; j++) begin
                pe_psum[j] <= PBW'(((j == 0) ? 0 : int'(pe_psum[(j == 0) ? 0 : j-1]))
                                   + int'($signed(pe_w[j])) * int'($signed(din[j*DBW +: DBW])));
            end
        end
    end
    assign row_result = pe_psum[MS-1];

    // Reference model state.
    typedef struct { int cyc; logic [PBW-1:0] val; } ev_t;
    ev_t             evq[$];
    logic [63:0]     hist[int];
    logic [63:0]     m_w;
    logic [PBW-1:0]  exp_out;
    int cyc, load_cyc, done_cyc, stream_from, idle_from, busy_from;
    bit stream_on, w_acc_now, in_acc_now;
    int m_busy_cnt, m_vec_cnt;
    int n_checks = 0, n_pass = 0, n_fail = 0;

    function automatic logic [PBW-1:0] dot(input logic [63:0] w, input logic [63:0] d);
        int s = 0;
        for (int i = 0; i < MS; i++)
            s += int'($signed(w[i*8 +: 8])) * int'($signed(d[i*8 +: 8]));
        return s[PBW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s observed=timeout expected=accept cycle=%0d", tag, cyc);
    endtask

    task automatic model_clear();
        evq.delete();
        hist.delete();
        m_w = '0; exp_out = '0;
        load_cyc = -1; done_cyc = -1;
        stream_on = 1'b0; stream_from = BIG; idle_from = BIG; busy_from = BIG;
        m_busy_cnt = 0; m_vec_cnt = 0;
    endtask

    task automatic check_cycle();
        logic [63:0] exp_din, hv;
        bit ev;
        ev = (evq.size() > 0) && (evq[0].cyc == cyc);
        if (ev) begin
            exp_out = evq[0].val;
            void'(evq.pop_front());
        end
        chk("out_valid", bus.out_valid, ev);
        chk("out_data",  bus.out_data,  exp_out);
        chk("done",      done,          cyc == done_cyc);
        chk("w_ready",   bus.w_ready,   cyc >= idle_from);
        chk("in_ready",  bus.in_ready,  stream_on && (cyc >= stream_from));
        chk("we_rl",     we_rl,         cyc == load_cyc);
        chk("busy",      busy,          (cyc >= busy_from) && (cyc < idle_from));
        chk("weights",   weights,       m_w);
        exp_din = '0;
        for (int i = 0; i < MS; i++) begin
            if (hist.exists(cyc - 1 - i*PEL)) begin
                hv = hist[cyc - 1 - i*PEL];
                exp_din[i*DBW +: DBW] = hv[i*DBW +: DBW];
            end
        end
        chk("din", din, exp_din);
`ifdef SA_ROW_CTRL_PERF_EN
        chk("perf_busy", perf_busy_cycles, m_busy_cnt);
        chk("perf_vec",  perf_vec_count,   m_vec_cnt);
`endif
    endtask

    // One clock: check at negedge, then drive and advance the reference.
    task automatic tick(input bit wv, input logic [63:0] wd, input bit iv,
                        input logic [63:0] id, input bit il);
        @(negedge clk);
        cyc++;
        check_cycle();
        if ((cyc >= busy_from) && (cyc < idle_from)) m_busy_cnt++;
        bus.w_valid = wv; bus.w_data = wd;
        bus.in_valid = iv; bus.in_data = id; bus.in_last = il;
        w_acc_now  = rstn && wv && (cyc >= idle_from);
        in_acc_now = rstn && iv && stream_on && (cyc >= stream_from);
        if (w_acc_now) begin
            m_w = wd;
            load_cyc = cyc + 1; stream_from = cyc + 2; stream_on = 1'b1;
            busy_from = cyc + 1; idle_from = BIG;
        end
        if (in_acc_now) begin
            hist[cyc] = id;
            evq.push_back('{cyc: cyc + LAT + 1, val: dot(m_w, id)});
            m_vec_cnt++;
            if (il) begin
                stream_on = 1'b0;
                done_cyc  = cyc + LAT + 1;
                idle_from = cyc + LAT + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic load(input logic [63:0] wd);
        bit ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            tick(1'b1, wd, 1'b0, '0, 1'b0);
            ok = w_acc_now;
        end
        if (!ok) bound_fail("load_timeout");
    endtask

    task automatic send(input logic [63:0] id, input bit il);
        bit ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            tick(1'b0, '0, 1'b1, id, il);
            ok = in_acc_now;
        end
        if (!ok) bound_fail("send_timeout");
    endtask

    task automatic wait_idle();
        int k = 0;
        while (((cyc < idle_from) || (evq.size() > 0)) && (k < 60)) begin
            idle(1);
            k++;
        end
        if (k >= 60) bound_fail("idle_timeout");
    endtask

    // Async reset: outputs must clear immediately, then hold and release.
    task automatic reset_seq(input int hold);
        rstn = 1'b0;
        model_clear();
        bus.w_valid = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_done",      done,          0);
        chk("rst_busy",      busy,          0);
        chk("rst_we_rl",     we_rl,         0);
        chk("rst_w_ready",   bus.w_ready,   0);
        chk("rst_in_ready",  bus.in_ready,  0);
        chk("rst_weights",   weights,       0);
        chk("rst_din",       din,           0);
        idle(hold);
        rstn = 1'b1;
        idle_from = cyc + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] wd, vd;
        int len, gaps;
        cyc = 0;
        bus.w_valid = 1'b0; bus.w_data = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        model_clear();
        #2;
        reset_seq(3);
        idle(2);

        // All-ones weights, single vector with last: result 36.
        load(64'h0101_0101_0101_0101);
        send(64'h0807_0605_0403_0201, 1'b1);
        wait_idle();

        // Alternating +1/-1 weights, four back-to-back vectors of 5: zeros.
        load(64'hFF01_FF01_FF01_FF01);
        for (int k = 0; k < 4; k++) send(64'h0505_0505_0505_0505, k == 3);
        wait_idle();

        // Weights 1..8, valid pattern 1,0,1.
        load(64'h0807_0605_0403_0201);
        send({$urandom(), $urandom()}, 1'b0);
        idle(1);
        send({$urandom(), $urandom()}, 1'b1);
        wait_idle();

        // Signed extremes.
        load(64'h8080_8080_8080_8080);
        send(64'h8080_8080_8080_8080, 1'b1);
        wait_idle();
        load(64'h8080_8080_8080_8080);
        send(64'h7F7F_7F7F_7F7F_7F7F, 1'b1);
        wait_idle();

        // w_valid offered during STREAM must be ignored.
        load({$urandom(), $urandom()});
        send({$urandom(), $urandom()}, 1'b0);
        tick(1'b1, {$urandom(), $urandom()}, 1'b1, {$urandom(), $urandom()}, 1'b0);
        tick(1'b1, {$urandom(), $urandom()}, 1'b1, {$urandom(), $urandom()}, 1'b0);
        send({$urandom(), $urandom()}, 1'b1);
        wait_idle();

        // Reset with three vectors in flight, then a normal stream.
        load({$urandom(), $urandom()});
        for (int k = 0; k < 3; k++) send({$urandom(), $urandom()}, 1'b0);
        reset_seq(2);
        idle(15);
        load({$urandom(), $urandom()});
        send({$urandom(), $urandom()}, 1'b0);
        send({$urandom(), $urandom()}, 1'b1);
        wait_idle();

        // Randomized streams with random lengths and gaps.
        for (int s = 0; s < 6; s++) begin
            wd = {$urandom(), $urandom()};
            load(wd);
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                gaps = $urandom_range(0, 2);
                idle(gaps);
                vd = {$urandom(), $urandom()};
                send(vd, k == len - 1);
            end
            wait_idle();
        end

        idle(5);
        chk("pending_results", evq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sa_row_ctrl.md
Name: sa_row_ctrl

Overview:
- Controller/sequencer for one horizontal systolic PE row (MATRIX_SIZE PEs chained on the partial-sum path).
- Loads the row's weights and pulses the row's weight-latch strobe.
- Accepts unskewed input vectors through a valid/ready handshake and applies the per-PE diagonal skew so the partial sums align.
- Tracks in-flight vectors and captures the row's final partial sum as a registered, validated output stream.

Parameters:
- WEIGHT_BW, 8, weight element width
- DATA_BW, 8, input element width
- PSUM_BW, 20, partial-sum/result width
- MATRIX_SIZE, 8, PEs in the row
- PE_LAT, 1, psum register stages per PE (≥1)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- w_valid  in  1  weight vector offered
- w_ready  out  1  controller accepts weights (IDLE only)
- w_data  in  MATRIX_SIZE*WEIGHT_BW  weight vector, element i at [i*WEIGHT_BW +: WEIGHT_BW]
- in_valid  in  1  input vector offered
- in_ready  out  1  controller accepts input (STREAM only)
- in_data  in  MATRIX_SIZE*DATA_BW  unskewed input vector
- in_last  in  1  marks final vector of a stream (qualified by in_valid&in_ready)
- we_rl  out  1  weight-latch strobe to the row
- weights  out  MATRIX_SIZE*WEIGHT_BW  registered weights to the row
- din  out  MATRIX_SIZE*DATA_BW  skewed data to the row
- row_result  in  PSUM_BW  final psum from last PE (signed)
- out_valid  out  1  out_data valid, single-cycle, no backpressure
- out_data  out  PSUM_BW  captured signed result
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at DRAIN→IDLE

Behaviour:
- Reset (async, rstn=0): state=IDLE; all outputs, skew registers, valid shift register and counters = 0.
- States: IDLE, LOAD, STREAM, DRAIN.
- IDLE: w_ready=1, in_ready=0.
  - w_valid → latch w_data into weights; go to LOAD.
  - in_valid is ignored.
- LOAD (exactly 1 cycle): we_rl=1, weights stable; go to STREAM.
- STREAM: in_ready=1.
  - Each cycle, element i of the accepted vector enters a skew delay of i*PE_LAT cycles before driving din slot i.
  - Element 0 is delayed 0 cycles but still passes through the din output register.
  - Cycles with no handshake inject zero on every lane, and a 0 bit into the valid tracker.
  - Accepting a vector with in_last → DRAIN.
- DRAIN: in_ready=0, zeros injected.
  - A countdown of LAT=MATRIX_SIZE*PE_LAT+1 cycles flushes the pipe.
  - At zero: done=1 for one cycle, state → IDLE.
- Latency: accepted vector at cycle t → out_valid at t+LAT+1; out_data=row_result registered from cycle t+LAT.
- Valid tracker: shift register of depth LAT. Its tap gates the out_data capture; out_data holds its value when out_valid=0.
- Throughput: one vector per cycle in STREAM; back-to-back results are allowed.
- Weights are changed only via IDLE, so there is no reload mid-stream. w_valid outside IDLE is ignored, with w_ready=0.
- Simultaneous in_valid and in_last on the first STREAM cycle (single-vector stream) is legal.
- rstn deasserted mid-operation: immediate abort, in-flight results discarded, no done pulse.
- Arithmetic: the controller does no arithmetic on data; psum is passed through sign-preserved at PSUM_BW.

Optional Feature:
- Macro SA_ROW_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_busy_cycles[31:0] (cycles with busy=1) and perf_vec_count[31:0] (accepted input vectors).
  - Both counters saturate at all-ones and clear on reset only.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sa_pkg holds:
  - state enum (IDLE/LOAD/STREAM/DRAIN)
  - default widths DATA_BW/WEIGHT_BW/PSUM_BW
  - function computing LAT from MATRIX_SIZE and PE_LAT
- Sub-module sa_skew_line: one lane, parameterised depth (0 allowed = wire), zero-reset shift register. Instantiated MATRIX_SIZE times by generate.
- FSM, valid tracker and capture logic live in sa_row_ctrl.

Test Plan:
- Weights all 1, single vector in_data={8,7,...,1} with in_last → we_rl single pulse after w accept; out_data=36 exactly LAT+1 cycles after accept; done one cycle after flush.
- Weights {1,-1,1,-1,...}, 4 back-to-back vectors all 5 → four consecutive out_valid cycles, each out_data=0.
- Weights i+1 (1..8), vectors with in_valid gaps (valid pattern 1,0,1) → exactly 2 out_valid pulses, spaced 2 cycles apart, values matching the golden dot product.
- Signed extremes: weights all -128, inputs all -128 → out_data=131072 (fits 20-bit signed); weights -128 with inputs 127 → -130048.
- w_valid and in_valid asserted during STREAM → w_ready=0, weights unchanged, we_rl stays 0.
- rstn pulled low mid-STREAM with 3 vectors in flight → all outputs 0 immediately, no out_valid or done afterwards, a new load sequence works normally.
